// File: rtl/cop_issue_wb.sv
// Issue/writeback stage for the custom-instruction coprocessor port: one CUSTOM_0..3 op in flight, 1-entry result buffer.
// Latency: accept at N, request on the coprocessor bus at N+1, zero-wait result visible on wb_* at N+2.
// Backpressure: req_ready only while idle; a full, undrained result buffer holds the request in place via cop_rdywr.
module cop_issue_wb #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        cop_clk,
   input  logic        cop_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_insn,
   input  logic [63:0] req_rs1,
   input  logic [63:0] req_rs2,
   output logic        cop_valid,
   output logic [31:0] cop_insn,
   output logic [63:0] cop_rs1,
   output logic [63:0] cop_rs2,
   output logic        cop_rdywr,
   input  logic        cop_ready,
   input  logic        cop_wait,
   input  logic        cop_wr,
   input  logic [63:0] cop_rd,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_idx,
   output logic [63:0] wb_data,
   output logic        unclaimed,
   output logic        timeout,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
   localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [TO_W-1:0] wait_cnt;

   logic is_custom;
   logic in_flight;
   logic expire;
   logic complete;
   logic capture;
   logic drain;
   logic no_claim;

   // The four CUSTOM_0..3 major opcodes are the only ones routed to the coprocessor.
   assign is_custom = (req_insn[6:0] == 7'b0001011) || (req_insn[6:0] == 7'b0101011) ||
                      (req_insn[6:0] == 7'b1011011) || (req_insn[6:0] == 7'b1111011);

   assign in_flight = (state == ST_ISSUE) || (state == ST_WAIT);
   assign req_ready = (state == ST_IDLE);
   assign cop_valid = in_flight;
   assign busy      = (state != ST_IDLE);

   // A drain in the same cycle frees the slot, so capture and drain can overlap.
   assign drain     = wb_valid & wb_ready;
   assign cop_rdywr = ~wb_valid | wb_ready;

   // cop_wait outranks cop_wr; the write completes only when both sides can take it.
   assign expire   = (state == ST_WAIT) && cop_wait && (wait_cnt == TO_LIM);
   assign complete = in_flight && !cop_wait && cop_wr && cop_ready && cop_rdywr;
   // Results aimed at x0 are dropped without touching the buffer.
   assign capture  = complete && (cop_insn[11:7] != 5'd0);
   assign no_claim = (req_ready && req_valid && !is_custom) ||
                     (in_flight && !cop_wait && !cop_wr);

   // Next-state selection for the request handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_valid && is_custom) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (cop_wait) begin
               state_nxt = expire ? ST_IDLE : ST_WAIT;
            end else if (cop_wr) begin
               state_nxt = complete ? ST_IDLE : state;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register plus the one-cycle status pulses derived from this cycle's decision.
   always_ff @(posedge cop_clk or negedge cop_rst) begin
      if (!cop_rst) begin
         state     <= ST_IDLE;
         unclaimed <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         unclaimed <= no_claim;
         timeout   <= expire;
      end
   end

   // Wait counter: first stall cycle loads 1, later stall cycles count up and stick at all-ones.
   always_ff @(posedge cop_clk or negedge cop_rst) begin
      if (!cop_rst) begin
         wait_cnt <= '0;
      end else if ((state == ST_ISSUE) && cop_wait) begin
         wait_cnt <= CNT_ONE;
      end else if ((state == ST_WAIT) && cop_wait && !expire && (wait_cnt != CNT_MAX)) begin
         wait_cnt <= wait_cnt + CNT_ONE;
      end
   end

   // Request operands are captured on acceptance and stay frozen while the op is in flight.
   always_ff @(posedge cop_clk or negedge cop_rst) begin
      if (!cop_rst) begin
         cop_insn <= '0;
         cop_rs1  <= '0;
         cop_rs2  <= '0;
      end else if (req_ready && req_valid && is_custom) begin
         cop_insn <= req_insn;
         cop_rs1  <= req_rs1;
         cop_rs2  <= req_rs2;
      end
   end

   // Single-entry result buffer; a capture wins over a simultaneous drain.
   always_ff @(posedge cop_clk or negedge cop_rst) begin
      if (!cop_rst) begin
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_data  <= '0;
      end else if (capture) begin
         wb_valid <= 1'b1;
         wb_idx   <= cop_insn[11:7];
         wb_data  <= cop_rd;
      end else if (drain) begin
         wb_valid <= 1'b0;
      end
   end

endmodule
